// File: rtl/alu_issue_if.sv
// Handshake and forwarding bundle between ID, the EX issue stage and the ALU.
// master = environment (ID, forwarding sources, ALU); slave = alu_issue_stage.
interface alu_issue_if #(
    parameter int N    = 64,
    parameter int REGW = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [REGW-1:0] in_rs1_idx;
    logic [REGW-1:0] in_rs2_idx;
    logic [N-1:0]    in_rs1_val;
    logic [N-1:0]    in_rs2_val;
    logic [N-1:0]    in_imm;
    logic            in_use_imm;
    logic [3:0]      in_alu_ctrl;
    logic [REGW-1:0] in_rd_idx;
    logic            fwd_mem_en;
    logic [REGW-1:0] fwd_mem_rd;
    logic [N-1:0]    fwd_mem_val;
    logic            fwd_wb_en;
    logic [REGW-1:0] fwd_wb_rd;
    logic [N-1:0]    fwd_wb_val;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    alu_a;
    logic [N-1:0]    alu_b;
    logic [3:0]      alu_ctrl;
    logic [REGW-1:0] out_rd_idx;
    logic [31:0]     perf_issue_cnt;
    logic [31:0]     perf_stall_cnt;

    modport master (
        output flush, in_valid, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_alu_ctrl, in_rd_idx,
               fwd_mem_en, fwd_mem_rd, fwd_mem_val, fwd_wb_en, fwd_wb_rd, fwd_wb_val,
               out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_rd_idx,
               perf_issue_cnt, perf_stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_rs1_idx, in_rs2_idx, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_alu_ctrl, in_rd_idx,
               fwd_mem_en, fwd_mem_rd, fwd_mem_val, fwd_wb_en, fwd_wb_rd, fwd_wb_val,
               out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_rd_idx,
               perf_issue_cnt, perf_stall_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// EX issue buffer: resolves MEM/WB forwarding at accept, holds ops in a 2-entry skid FIFO.
// Optional perf counters enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
    parameter int N    = 64,
    parameter int REGW = 5
) (
    input logic        clk,
    input logic        reset,
    alu_issue_if.slave bus
);
    localparam logic [REGW-1:0] XZR = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                   state_p1, state_next;
    logic                   in_ready_p1;
    logic                   vld_p1;
    logic                   accept, issue;
    logic                   load_main, load_skid, main_from_skid;
    logic signed [N-1:0]    res_a, res_b;

    logic signed [N-1:0]    main_a_p1, main_b_p1;
    logic [3:0]             main_ctrl_p1;
    logic [REGW-1:0]        main_rd_p1;
    logic signed [N-1:0]    skid_a_p0, skid_b_p0;
    logic [3:0]             skid_ctrl_p0;
    logic [REGW-1:0]        skid_rd_p0;

    // XZR is hard zero and never forwarded; MEM is younger than WB so it wins.
    function automatic logic signed [N-1:0] resolve(
        input logic [REGW-1:0]   idx,
        input logic signed [N-1:0] rf_val,
        input logic              mem_en,
        input logic [REGW-1:0]   mem_rd,
        input logic signed [N-1:0] mem_val,
        input logic              wb_en,
        input logic [REGW-1:0]   wb_rd,
        input logic signed [N-1:0] wb_val
    );
        if (idx == XZR)
            return '0;
        else if (mem_en && (mem_rd == idx))
            return mem_val;
        else if (wb_en && (wb_rd == idx))
            return wb_val;
        else
            return rf_val;
    endfunction

    assign vld_p1 = (state_p1 != EMPTY);
    assign accept = bus.in_valid & in_ready_p1;
    assign issue  = vld_p1 & bus.out_ready;

    always_comb begin
        res_a = resolve(bus.in_rs1_idx, bus.in_rs1_val,
                        bus.fwd_mem_en, bus.fwd_mem_rd, bus.fwd_mem_val,
                        bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_val);
        if (bus.in_use_imm)
            res_b = bus.in_imm;
        else
            res_b = resolve(bus.in_rs2_idx, bus.in_rs2_val,
                            bus.fwd_mem_en, bus.fwd_mem_rd, bus.fwd_mem_val,
                            bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_val);
    end

    always_comb begin
        state_next     = state_p1;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush) begin
            state_next = EMPTY;
        end else begin
            case (state_p1)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (issue) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (issue) begin
                        state_next     = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Control: occupancy and registered ready
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1    <= EMPTY;
            in_ready_p1 <= 1'b1;
        end else begin
            state_p1    <= state_next;
            in_ready_p1 <= (state_next != TWO);
        end
    end

    // Main entry drives the ALU; cleared on reset so alu_* read zero
    always_ff @(posedge clk) begin
        if (reset) begin
            main_a_p1    <= '0;
            main_b_p1    <= '0;
            main_ctrl_p1 <= '0;
            main_rd_p1   <= '0;
        end else if (load_main) begin
            main_a_p1    <= res_a;
            main_b_p1    <= res_b;
            main_ctrl_p1 <= bus.in_alu_ctrl;
            main_rd_p1   <= bus.in_rd_idx;
        end else if (main_from_skid) begin
            main_a_p1    <= skid_a_p0;
            main_b_p1    <= skid_b_p0;
            main_ctrl_p1 <= skid_ctrl_p0;
            main_rd_p1   <= skid_rd_p0;
        end
    end

    // Skid entry: only meaningful while in TWO
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_a_p0    <= res_a;
            skid_b_p0    <= res_b;
            skid_ctrl_p0 <= bus.in_alu_ctrl;
            skid_rd_p0   <= bus.in_rd_idx;
        end
    end

    assign bus.in_ready   = in_ready_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.alu_a      = main_a_p1;
    assign bus.alu_b      = main_b_p1;
    assign bus.alu_ctrl   = main_ctrl_p1;
    assign bus.out_rd_idx = main_rd_p1;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issue_cnt_p1, stall_cnt_p1;

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_p1 <= '0;
            stall_cnt_p1 <= '0;
        end else begin
            if (issue)
                issue_cnt_p1 <= issue_cnt_p1 + 32'd1;
            if (vld_p1 && !bus.out_ready)
                stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
        end
    end

    assign bus.perf_issue_cnt = issue_cnt_p1;
    assign bus.perf_stall_cnt = stall_cnt_p1;
`else
    assign bus.perf_issue_cnt = 32'd0;
    assign bus.perf_stall_cnt = 32'd0;
`endif
endmodule
